// File: rtl/kbd_matrix_latch_if.sv
// Keyboard event / PPI scan bundle between the key decoder, the latch and the CPU side.
// The slave side is the latch itself; the master side drives events and row selects.
interface kbd_matrix_latch_if;
    logic       key_stb;
    logic       key_break;
    logic [7:0] scancode;
    logic [2:0] qrow;
    logic [2:0] qcol;
    logic       qerror;
    logic       clear_all;
    logic [7:0] rowsel_n;
    logic [7:0] colbits_n;
    logic       shift_n;
    logic       ctrl_n;
    logic       ruslat_n;
    logic       any_key;

    modport master (
        output key_stb, key_break, scancode, qrow, qcol, qerror, clear_all, rowsel_n,
        input  colbits_n, shift_n, ctrl_n, ruslat_n, any_key
    );

    modport slave (
        input  key_stb, key_break, scancode, qrow, qcol, qerror, clear_all, rowsel_n,
        output colbits_n, shift_n, ctrl_n, ruslat_n, any_key
    );
endinterface

// File: rtl/kbd_matrix_latch.sv
// Vector-06C key-state store: 8x8 matrix plus modifiers, with releases deferred until
// a minimum hold time has elapsed since the last newly pressed key.
module kbd_matrix_latch #(
    parameter int HOLD_CYCLES = 480000,
    parameter int HOLD_W      = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    kbd_matrix_latch_if.slave     kbd
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    hold_state_t       state_r, state_s;
    logic [HOLD_W-1:0] cnt_r, cnt_s;
    logic [63:0]       matrix_r, matrix_s;
    logic [63:0]       pending_r, pending_s;
    logic              s12_r, s12_s;
    logic              s59_r, s59_s;
    logic              ctrl_r, ctrl_s;
    logic              rus_r, rus_s;
    logic [5:0]        idx_s;

    logic [7:0]        colbits_n_r;
    logic              shift_n_r;
    logic              ctrl_n_r;
    logic              ruslat_n_r;
    logic              any_key_r;

    // OR together the column bytes of every row whose select line is low.
    function automatic logic [7:0] col_or(input logic [63:0] m, input logic [7:0] sel_n);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc | (m[i*8 +: 8] & {8{~sel_n[i]}});
        end
        return acc;
    endfunction

    assign idx_s = {kbd.qrow, kbd.qcol};

    // Next-state: timer expiry first, then clear_all or the incoming key event.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        matrix_s  = matrix_r;
        pending_s = pending_r;
        s12_s     = s12_r;
        s59_s     = s59_r;
        ctrl_s    = ctrl_r;
        rus_s     = rus_r;

        case (state_r)
            HOLD: begin
                if (cnt_r == HOLD_ONE) begin
                    matrix_s  = matrix_r & ~pending_r;
                    pending_s = 64'h0;
                    cnt_s     = {HOLD_W{1'b0}};
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r - HOLD_ONE;
                end
            end
            IDLE: begin
                cnt_s = {HOLD_W{1'b0}};
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {HOLD_W{1'b0}};
            end
        endcase

        if (kbd.clear_all) begin
            matrix_s  = 64'h0;
            pending_s = 64'h0;
            cnt_s     = {HOLD_W{1'b0}};
            state_s   = IDLE;
            s12_s     = 1'b0;
            s59_s     = 1'b0;
            ctrl_s    = 1'b0;
            rus_s     = 1'b0;
        end else if (kbd.key_stb) begin
            case (kbd.scancode)
                8'h12:   s12_s  = ~kbd.key_break;
                8'h59:   s59_s  = ~kbd.key_break;
                8'h14:   ctrl_s = ~kbd.key_break;
                8'h58:   rus_s  = ~kbd.key_break;
                default: rus_s  = rus_s;
            endcase

            if (kbd.qerror) begin
                matrix_s = matrix_s;
            end else if (!kbd.key_break) begin
                // Only a newly pressed key restarts the timer; typematic repeats just cancel a release.
                if (!matrix_s[idx_s]) begin
                    matrix_s[idx_s]  = 1'b1;
                    pending_s[idx_s] = 1'b0;
                    cnt_s            = HOLD_LOAD;
                    state_s          = HOLD;
                end else begin
                    pending_s[idx_s] = 1'b0;
                end
            end else if (state_s == IDLE) begin
                matrix_s[idx_s] = 1'b0;
            end else begin
                pending_s[idx_s] = 1'b1;
            end
        end else begin
            matrix_s = matrix_s;
        end
    end

    // State registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {HOLD_W{1'b0}};
            matrix_r    <= 64'h0;
            pending_r   <= 64'h0;
            s12_r       <= 1'b0;
            s59_r       <= 1'b0;
            ctrl_r      <= 1'b0;
            rus_r       <= 1'b0;
            colbits_n_r <= 8'hFF;
            shift_n_r   <= 1'b1;
            ctrl_n_r    <= 1'b1;
            ruslat_n_r  <= 1'b1;
            any_key_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            matrix_r    <= matrix_s;
            pending_r   <= pending_s;
            s12_r       <= s12_s;
            s59_r       <= s59_s;
            ctrl_r      <= ctrl_s;
            rus_r       <= rus_s;
            colbits_n_r <= ~col_or(matrix_r, kbd.rowsel_n);
            shift_n_r   <= ~(s12_s | s59_s);
            ctrl_n_r    <= ~ctrl_s;
            ruslat_n_r  <= ~rus_s;
            any_key_r   <= (|matrix_s) | s12_s | s59_s | ctrl_s | rus_s;
        end
    end

    assign kbd.colbits_n = colbits_n_r;
    assign kbd.shift_n   = shift_n_r;
    assign kbd.ctrl_n    = ctrl_n_r;
    assign kbd.ruslat_n  = ruslat_n_r;
    assign kbd.any_key   = any_key_r;

endmodule

// File: tb/tb_kbd_matrix_latch.sv
// Directed bench for kbd_matrix_latch: a vector table for single-cycle behaviour plus
// hand-written sequences for the hold-timer corner cases (HOLD_CYCLES = 100).
module tb_kbd_matrix_latch;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    kbd_matrix_latch_if kif ();

    kbd_matrix_latch #(
        .HOLD_CYCLES(100),
        .HOLD_W     (7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kbd  (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic       brk;
        logic [7:0] code;
        logic [2:0] row;
        logic [2:0] col;
        logic       err;
        logic       clr;
        logic [7:0] rowsel;
        logic [7:0] exp_col;
        logic       exp_shift;
        logic       exp_ctrl;
        logic       exp_rus;
        logic       exp_any;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mkv(input logic stb, input logic brk, input logic [7:0] code,
                                 input logic [2:0] row, input logic [2:0] col, input logic err,
                                 input logic clr, input logic [7:0] rowsel, input logic [7:0] ec,
                                 input logic es, input logic et, input logic er, input logic ea);
        vec_t v;
        v.stb = stb; v.brk = brk; v.code = code; v.row = row; v.col = col; v.err = err;
        v.clr = clr; v.rowsel = rowsel; v.exp_col = ec; v.exp_shift = es; v.exp_ctrl = et;
        v.exp_rus = er; v.exp_any = ea;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic ev(input logic brk, input logic [7:0] code, input logic [2:0] row,
                      input logic [2:0] col, input logic err);
        kif.key_stb   = 1'b1;
        kif.key_break = brk;
        kif.scancode  = code;
        kif.qrow      = row;
        kif.qcol      = col;
        kif.qerror    = err;
        tick();
        kif.key_stb   = 1'b0;
        kif.key_break = 1'b0;
        kif.qerror    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk8({name, "_col"}, kif.colbits_n, 8'hFF);
        chk1({name, "_shift"}, kif.shift_n, 1'b1);
        chk1({name, "_ctrl"}, kif.ctrl_n, 1'b1);
        chk1({name, "_rus"}, kif.ruslat_n, 1'b1);
        chk1({name, "_any"}, kif.any_key, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        kif.key_stb   = 1'b0;
        kif.key_break = 1'b0;
        kif.scancode  = 8'h00;
        kif.qrow      = 3'd0;
        kif.qcol      = 3'd0;
        kif.qerror    = 1'b0;
        kif.clear_all = 1'b0;
        kif.rowsel_n  = 8'hFF;

        vecs[0]  = mkv(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[1]  = mkv(1'b1, 1'b0, 8'h12, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[2]  = mkv(1'b1, 1'b0, 8'h59, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[3]  = mkv(1'b1, 1'b1, 8'h12, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[4]  = mkv(1'b1, 1'b1, 8'h59, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mkv(1'b1, 1'b0, 8'h14, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[6]  = mkv(1'b1, 1'b0, 8'h58, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mkv(1'b1, 1'b1, 8'h14, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[8]  = mkv(1'b1, 1'b1, 8'h58, 3'd0, 3'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mkv(1'b1, 1'b0, 8'h1C, 3'd2, 3'd3, 1'b0, 1'b0, 8'hFB, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[10] = mkv(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFB, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[11] = mkv(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[12] = mkv(1'b1, 1'b0, 8'h76, 3'd4, 3'd4, 1'b1, 1'b0, 8'hEF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[13] = mkv(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'hEF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[14] = mkv(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[15] = mkv(1'b1, 1'b0, 8'h12, 3'd0, 3'd0, 1'b1, 1'b1, 8'h00, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[16] = mkv(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset state
        idle(2);
        chk_reset_vals("reset");
        reset = 1'b0;
        idle(1);

        // Vector table: modifiers, qerror, row reads, clear_all priority
        for (int i = 0; i < 17; i++) begin
            kif.key_stb   = vecs[i].stb;
            kif.key_break = vecs[i].brk;
            kif.scancode  = vecs[i].code;
            kif.qrow      = vecs[i].row;
            kif.qcol      = vecs[i].col;
            kif.qerror    = vecs[i].err;
            kif.clear_all = vecs[i].clr;
            kif.rowsel_n  = vecs[i].rowsel;
            tick();
            chk8($sformatf("vec%0d_col", i), kif.colbits_n, vecs[i].exp_col);
            chk1($sformatf("vec%0d_shift", i), kif.shift_n, vecs[i].exp_shift);
            chk1($sformatf("vec%0d_ctrl", i), kif.ctrl_n, vecs[i].exp_ctrl);
            chk1($sformatf("vec%0d_rus", i), kif.ruslat_n, vecs[i].exp_rus);
            chk1($sformatf("vec%0d_any", i), kif.any_key, vecs[i].exp_any);
        end
        kif.key_stb   = 1'b0;
        kif.key_break = 1'b0;
        kif.qerror    = 1'b0;
        kif.clear_all = 1'b0;

        // Deferred release: make at E0, break at E10, matrix clears at E100
        kif.rowsel_n = 8'hFB;
        ev(1'b0, 8'h1C, 3'd2, 3'd3, 1'b0);
        idle(9);
        ev(1'b1, 8'h1C, 3'd2, 3'd3, 1'b0);
        chk1("hold_break_any", kif.any_key, 1'b1);
        idle(89);
        chk8("hold_e99_col", kif.colbits_n, 8'hF7);
        chk1("hold_e99_any", kif.any_key, 1'b1);
        idle(1);
        chk1("hold_e100_any", kif.any_key, 1'b0);
        chk8("hold_e100_col", kif.colbits_n, 8'hF7);
        idle(1);
        chk8("hold_e101_col", kif.colbits_n, 8'hFF);

        // Typematic repeats do not restart the timer; late break is immediate
        kif.rowsel_n = 8'hFE;
        ev(1'b0, 8'h16, 3'd0, 3'd1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            idle(29);
            ev(1'b0, 8'h16, 3'd0, 3'd1, 1'b0);
        end
        idle(9);
        chk8("rep_e249_col", kif.colbits_n, 8'hFD);
        chk1("rep_e249_any", kif.any_key, 1'b1);
        ev(1'b1, 8'h16, 3'd0, 3'd1, 1'b0);
        chk1("rep_e250_any", kif.any_key, 1'b0);
        idle(1);
        chk8("rep_e251_col", kif.colbits_n, 8'hFF);

        // Two rows selected at once
        kif.rowsel_n = 8'hDD;
        ev(1'b0, 8'h15, 3'd1, 3'd0, 1'b0);
        ev(1'b0, 8'h4A, 3'd5, 3'd7, 1'b0);
        idle(99);
        chk8("multi_col", kif.colbits_n, 8'h7E);
        idle(1);
        ev(1'b1, 8'h15, 3'd1, 3'd0, 1'b0);
        chk1("multi_brk_any", kif.any_key, 1'b1);
        idle(1);
        chk8("multi_brk_col", kif.colbits_n, 8'h7F);
        ev(1'b1, 8'h4A, 3'd5, 3'd7, 1'b0);
        chk1("multi_brk2_any", kif.any_key, 1'b0);
        idle(1);
        chk8("multi_brk2_col", kif.colbits_n, 8'hFF);

        // Make coincident with expiry of a pending release of the same key
        kif.rowsel_n = 8'hF7;
        ev(1'b0, 8'h26, 3'd3, 3'd2, 1'b0);
        idle(4);
        ev(1'b1, 8'h26, 3'd3, 3'd2, 1'b0);
        idle(94);
        ev(1'b0, 8'h26, 3'd3, 3'd2, 1'b0);
        chk1("coinc_e100_any", kif.any_key, 1'b1);
        ev(1'b1, 8'h26, 3'd3, 3'd2, 1'b0);
        chk8("coinc_e101_col", kif.colbits_n, 8'hFB);
        idle(98);
        chk8("coinc_e199_col", kif.colbits_n, 8'hFB);
        chk1("coinc_e199_any", kif.any_key, 1'b1);
        idle(1);
        chk1("coinc_e200_any", kif.any_key, 1'b0);
        idle(1);
        chk8("coinc_e201_col", kif.colbits_n, 8'hFF);

        // Dual shift tracking, then clear_all
        kif.rowsel_n = 8'hFB;
        ev(1'b0, 8'h12, 3'd0, 3'd0, 1'b1);
        ev(1'b0, 8'h59, 3'd0, 3'd0, 1'b1);
        ev(1'b1, 8'h12, 3'd0, 3'd0, 1'b1);
        chk1("dshift_shift", kif.shift_n, 1'b0);
        ev(1'b0, 8'h1C, 3'd2, 3'd3, 1'b0);
        ev(1'b0, 8'h14, 3'd0, 3'd0, 1'b1);
        chk8("pre_clr_col", kif.colbits_n, 8'hF7);
        chk1("pre_clr_ctrl", kif.ctrl_n, 1'b0);
        kif.clear_all = 1'b1;
        tick();
        kif.clear_all = 1'b0;
        idle(1);
        chk_reset_vals("clr");

        // Asynchronous reset mid-HOLD discards the pending release
        ev(1'b0, 8'h1C, 3'd2, 3'd3, 1'b0);
        ev(1'b0, 8'h58, 3'd0, 3'd0, 1'b1);
        ev(1'b1, 8'h1C, 3'd2, 3'd3, 1'b0);
        chk8("prerst_col", kif.colbits_n, 8'hF7);
        chk1("prerst_rus", kif.ruslat_n, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        idle(2);
        reset = 1'b0;
        idle(2);
        chk_reset_vals("post_rst");
        idle(110);
        chk_reset_vals("post_rst_late");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
